// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, channel FSM states and address-to-index helper
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input int unsigned ofs);
    return addr >> ofs;
  endfunction
endpackage

// File: rtl/axi_lite_reg_decode.sv
// axi_lite_reg_decode: byte address -> register index, in-range and read-only flags
// Ports: addr (byte address in), idx (register index out), in_range (idx < NREG), ro (RO_MASK bit of idx)
module axi_lite_reg_decode
  import axi_lite_pkg::*;
#(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREG = 16,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic [ASIZE-1:0]         addr,
  output logic [$clog2(NREG)-1:0]  idx,
  output logic                     in_range,
  output logic                     ro
);
  logic [63:0] full_idx;
  assign full_idx = addr_to_idx(64'(addr), $clog2(DSIZE / 8));
  assign in_range = full_idx < 64'(NREG);
  assign idx = full_idx[$clog2(NREG)-1:0];
  assign ro = in_range & RO_MASK[idx];
endmodule

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: AXI4-Lite slave exposing NREG RW/RO registers
// Ports: axi_lite_* AXI4-Lite slave channels (sync active-low reset axi_lite_resetn),
//        reg_q flattened RW contents, reg_wr_pulse per-register commit strobe, status_in RO sources.
// Optional: define AXI_LITE_REG_DECERR_EN to answer out-of-range and RO-write accesses with SLVERR.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREG = 16,
  parameter logic [NREG-1:0] RO_MASK = '0,
  parameter logic [DSIZE-1:0] RST_VAL = '0
) (
  input  logic                   axi_lite_aclk,
  input  logic                   axi_lite_resetn,
  input  logic                   axi_lite_awvalid,
  output logic                   axi_lite_awready,
  input  logic [ASIZE-1:0]       axi_lite_awaddr,
  input  logic                   axi_lite_wvalid,
  output logic                   axi_lite_wready,
  input  logic [DSIZE-1:0]       axi_lite_wdata,
  output logic [1:0]             axi_lite_bresp,
  output logic                   axi_lite_bvalid,
  input  logic                   axi_lite_bready,
  input  logic                   axi_lite_arvalid,
  output logic                   axi_lite_arready,
  input  logic [ASIZE-1:0]       axi_lite_araddr,
  output logic                   axi_lite_rvalid,
  input  logic                   axi_lite_rready,
  output logic [DSIZE-1:0]       axi_lite_rdata,
  output logic [1:0]             axi_lite_rresp,
  output logic [NREG*DSIZE-1:0]  reg_q,
  output logic [NREG-1:0]        reg_wr_pulse,
  input  logic [NREG*DSIZE-1:0]  status_in
);
  localparam int IW = $clog2(NREG);
  wr_state_t w_state;
  rd_state_t r_state;
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, commit;
  logic [ASIZE-1:0] aw_addr_q, w_addr;
  logic [DSIZE-1:0] w_data_q, w_data;
  logic [IW-1:0] w_idx, r_idx;
  logic w_in_range, w_ro, r_in_range, r_ro, w_err, r_err;
  assign axi_lite_awready = w_state == W_IDLE && !aw_held;
  assign axi_lite_wready = w_state == W_IDLE && !w_held;
  assign axi_lite_bvalid = w_state == W_RESP;
  assign axi_lite_arready = r_state == R_IDLE;
  assign axi_lite_rvalid = r_state == R_DATA;
  assign aw_hs = axi_lite_awvalid & axi_lite_awready;
  assign w_hs = axi_lite_wvalid & axi_lite_wready;
  assign ar_hs = axi_lite_arvalid & axi_lite_arready;
  // a write commits once both halves are present, whether latched earlier or arriving now
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);
  assign w_addr = aw_held ? aw_addr_q : axi_lite_awaddr;
  assign w_data = w_held ? w_data_q : axi_lite_wdata;
`ifdef AXI_LITE_REG_DECERR_EN
  assign w_err = !w_in_range | w_ro;
  assign r_err = !r_in_range;
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif
  axi_lite_reg_decode #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREG(NREG), .RO_MASK(RO_MASK)) u_wdec (
    .addr(w_addr), .idx(w_idx), .in_range(w_in_range), .ro(w_ro)
  );
  axi_lite_reg_decode #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREG(NREG), .RO_MASK(RO_MASK)) u_rdec (
    .addr(axi_lite_araddr), .idx(r_idx), .in_range(r_in_range), .ro(r_ro)
  );
  always_ff @(posedge axi_lite_aclk) begin
    if (!axi_lite_resetn) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      axi_lite_bresp <= '0;
      reg_q <= {NREG{RST_VAL}};
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        w_state <= W_RESP;
        aw_held <= 1'b0;
        w_held <= 1'b0;
        axi_lite_bresp <= w_err ? SLVERR : OKAY;
        if (w_in_range && !w_ro) begin
          reg_q[w_idx*DSIZE +: DSIZE] <= w_data;
          reg_wr_pulse[w_idx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_addr_q <= axi_lite_awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data_q <= axi_lite_wdata;
        end
        if (w_state == W_RESP && axi_lite_bready) w_state <= W_IDLE;
      end
    end
  end
  // reg_q is sampled before this edge's write lands, so a same-cycle read sees the old value
  always_ff @(posedge axi_lite_aclk) begin
    if (!axi_lite_resetn) begin
      r_state <= R_IDLE;
      axi_lite_rdata <= '0;
      axi_lite_rresp <= '0;
    end else if (ar_hs) begin
      r_state <= R_DATA;
      axi_lite_rdata <= !r_in_range ? '0 : r_ro ? status_in[r_idx*DSIZE +: DSIZE] : reg_q[r_idx*DSIZE +: DSIZE];
      axi_lite_rresp <= r_err ? SLVERR : OKAY;
    end else if (axi_lite_rvalid && axi_lite_rready) begin
      r_state <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb_axi_lite_reg_bank: randomized scoreboard bench for axi_lite_reg_bank
module tb_axi_lite_reg_bank;
  logic clk = 1'b0;
  logic resetn;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [1:0] bresp, rresp;
  logic [511:0] reg_q, status_in;
  logic [15:0] reg_wr_pulse;
  int tests = 0, fails = 0;
  logic [31:0] mreg [16];
  logic [31:0] stat [16];
  logic [1:0] bq [$];
  logic [33:0] rq [$];

  always #5 clk = ~clk;

  axi_lite_reg_bank #(.ASIZE(32), .DSIZE(32), .NREG(16), .RO_MASK(16'h8000), .RST_VAL(32'h0)) dut (
    .axi_lite_aclk(clk), .axi_lite_resetn(resetn),
    .axi_lite_awvalid(awvalid), .axi_lite_awready(awready), .axi_lite_awaddr(awaddr),
    .axi_lite_wvalid(wvalid), .axi_lite_wready(wready), .axi_lite_wdata(wdata),
    .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready),
    .axi_lite_arvalid(arvalid), .axi_lite_arready(arready), .axi_lite_araddr(araddr),
    .axi_lite_rvalid(rvalid), .axi_lite_rready(rready), .axi_lite_rdata(rdata), .axi_lite_rresp(rresp),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a);
`ifdef AXI_LITE_REG_DECERR_EN
    return (idx_of(a) >= 16 || idx_of(a) == 15) ? 2'b10 : 2'b00;
`else
    return (a == a) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
`ifdef AXI_LITE_REG_DECERR_EN
    return idx_of(a) >= 16 ? 2'b10 : 2'b00;
`else
    return (a == a) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    int i = idx_of(a);
    return i >= 16 ? 32'h0 : i == 15 ? stat[15] : mreg[i];
  endfunction

  // scoreboard monitor: one pop per response handshake
  always @(negedge clk) begin
    if (resetn) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL b_unexpected: got bresp %0h with no expected response", bresp);
        end else chk("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL r_unexpected: got rdata %0h with no expected response", rdata);
        end else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
      end
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input int lead, input int bdel);
    int i = idx_of(a);
    logic [1:0] er = exp_bresp(a);
    bit wr = i < 16 && i != 15;
    int c = 0;
    bit ad = 0, wd = 0, ah, wh;
    bq.push_back(er);
    awaddr = a;
    wdata = d;
    while (!(ad && wd) && c < 50) begin
      awvalid = !ad && c >= (lead > 0 ? lead : 0);
      wvalid = !wd && c >= (lead < 0 ? -lead : 0);
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk);
      #1;
      ad |= ah;
      wd |= wh;
      c++;
      if (wd && !ad) chk("wready_after_w", wready, 0);
      if (ad && !wd) chk("awready_after_aw", awready, 0);
    end
    awvalid = 0;
    wvalid = 0;
    chk("write_accepted", ad && wd, 1);
    chk("bvalid_latency", bvalid, 1);
    chk("wr_pulse", reg_wr_pulse, wr ? (64'h1 << i) : 64'h0);
    if (wr) begin
      mreg[i] = d;
      chk("reg_q_after_write", reg_q[i*32 +: 32], d);
    end
    for (int k = 0; k < bdel; k++) begin
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, er);
      chk("awready_in_resp", awready, 0);
      chk("wready_in_resp", wready, 0);
      @(posedge clk);
      #1;
      chk("wr_pulse_clear", reg_wr_pulse, 0);
    end
    bready = 1;
    @(posedge clk);
    #1;
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
    chk("wr_pulse_idle", reg_wr_pulse, 0);
  endtask

  task automatic read_txn(input logic [31:0] a, input int rdel);
    logic [31:0] ed = exp_rdata(a);
    logic [1:0] er = exp_rresp(a);
    int c = 0;
    bit h = 0;
    rq.push_back({er, ed});
    araddr = a;
    arvalid = 1;
    while (!h && c < 50) begin
      h = arready;
      @(posedge clk);
      #1;
      c++;
    end
    arvalid = 0;
    chk("read_accepted", h, 1);
    chk("rvalid_latency", rvalid, 1);
    chk("arready_low", arready, 0);
    for (int k = 0; k < rdel; k++) begin
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, ed);
      chk("r_hold_resp", rresp, er);
      chk("arready_in_data", arready, 0);
      @(posedge clk);
      #1;
    end
    rready = 1;
    @(posedge clk);
    #1;
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  task automatic sweep();
    for (int i = 0; i < 15; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], mreg[i]);
    chk("reg_q[15]_ro_untouched", reg_q[15*32 +: 32], 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    awaddr = 0;
    araddr = 0;
    wdata = 0;
    for (int i = 0; i < 16; i++) begin
      stat[i] = $urandom;
      mreg[i] = 0;
    end
    stat[15] = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++) status_in[i*32 +: 32] = stat[i];
    repeat (3) @(posedge clk);
    #1;
    resetn = 1;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    sweep();
    write_txn(32'h08, 32'hDEADBEEF, 0, 0);
    write_txn(32'h04, 32'h12345678, 3, 0);
    read_txn(32'h04, 0);
    read_txn(32'h3C, 0);
    write_txn(32'h3C, 32'h0BADF00D, 0, 0);
    read_txn(32'h3C, 0);
    write_txn(32'h0C, 32'hA5A5_5A5A, -2, 5);
    read_txn(32'h0C, 5);
    write_txn(32'h10, 32'h11, 0, 0);
    fork
      write_txn(32'h10, 32'h55, 0, 0);
      read_txn(32'h10, 0);
    join
    read_txn(32'h10, 0);
    read_txn(32'h40, 0);
    write_txn(32'h44, 32'hFFFF_FFFF, 1, 1);
    sweep();
    awaddr = 32'h20;
    wdata = 32'h7777_7777;
    awvalid = 1;
    wvalid = 1;
    @(posedge clk);
    #1;
    awvalid = 0;
    wvalid = 0;
    chk("pre_reset_bvalid", bvalid, 1);
    resetn = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 1);
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    sweep();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] wa, ra;
      int op;
      wa = ($urandom_range(0, 17) << 2) | ($urandom % 4);
      ra = ($urandom_range(0, 17) << 2) | ($urandom % 4);
      op = $urandom % 3;
      if (op == 0) write_txn(wa, $urandom, $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      else if (op == 1) read_txn(ra, $urandom_range(0, 3));
      else fork
        write_txn(wa, $urandom, $urandom_range(0, 6) - 3, $urandom_range(0, 3));
        read_txn(ra, $urandom_range(0, 3));
      join
    end
    sweep();
    repeat (2) @(posedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
